// File: rtl/kerbin_axi_id_remap_if.sv
// AXI_BUS: AXI4 bus bundle shared by the crossbar side and the DDR3
// controller side of kerbin_axi_id_remap.
//   Parameters: address, data, ID and user widths.
//   Modports:   Master drives AW/W/AR and the B/R readies,
//               Slave drives the B/R channels and the AW/W/AR readies.
interface AXI_BUS #(
   parameter int unsigned AXI_ADDR_WIDTH = 64,
   parameter int unsigned AXI_DATA_WIDTH = 64,
   parameter int unsigned AXI_ID_WIDTH   = 10,
   parameter int unsigned AXI_USER_WIDTH = 1
);
   logic [AXI_ID_WIDTH-1:0]     aw_id;
   logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
   logic [7:0]                  aw_len;
   logic [2:0]                  aw_size;
   logic [1:0]                  aw_burst;
   logic                        aw_lock;
   logic [3:0]                  aw_cache;
   logic [2:0]                  aw_prot;
   logic [3:0]                  aw_qos;
   logic [3:0]                  aw_region;
   logic [AXI_USER_WIDTH-1:0]   aw_user;
   logic                        aw_valid;
   logic                        aw_ready;

   logic [AXI_DATA_WIDTH-1:0]   w_data;
   logic [AXI_DATA_WIDTH/8-1:0] w_strb;
   logic                        w_last;
   logic [AXI_USER_WIDTH-1:0]   w_user;
   logic                        w_valid;
   logic                        w_ready;

   logic [AXI_ID_WIDTH-1:0]     b_id;
   logic [1:0]                  b_resp;
   logic [AXI_USER_WIDTH-1:0]   b_user;
   logic                        b_valid;
   logic                        b_ready;

   logic [AXI_ID_WIDTH-1:0]     ar_id;
   logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
   logic [7:0]                  ar_len;
   logic [2:0]                  ar_size;
   logic [1:0]                  ar_burst;
   logic                        ar_lock;
   logic [3:0]                  ar_cache;
   logic [2:0]                  ar_prot;
   logic [3:0]                  ar_qos;
   logic [3:0]                  ar_region;
   logic [AXI_USER_WIDTH-1:0]   ar_user;
   logic                        ar_valid;
   logic                        ar_ready;

   logic [AXI_ID_WIDTH-1:0]     r_id;
   logic [AXI_DATA_WIDTH-1:0]   r_data;
   logic [1:0]                  r_resp;
   logic                        r_last;
   logic [AXI_USER_WIDTH-1:0]   r_user;
   logic                        r_valid;
   logic                        r_ready;

   modport Master (
      output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
             aw_qos, aw_region, aw_user, aw_valid,
      input  aw_ready,
      output w_data, w_strb, w_last, w_user, w_valid,
      input  w_ready,
      input  b_id, b_resp, b_user, b_valid,
      output b_ready,
      output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
             ar_qos, ar_region, ar_user, ar_valid,
      input  ar_ready,
      input  r_id, r_data, r_resp, r_last, r_user, r_valid,
      output r_ready
   );

   modport Slave (
      input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
             aw_qos, aw_region, aw_user, aw_valid,
      output aw_ready,
      input  w_data, w_strb, w_last, w_user, w_valid,
      output w_ready,
      output b_id, b_resp, b_user, b_valid,
      input  b_ready,
      input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
             ar_qos, ar_region, ar_user, ar_valid,
      output ar_ready,
      output r_id, r_data, r_resp, r_last, r_user, r_valid,
      input  r_ready
   );
endinterface

// File: rtl/kerbin_axi_id_remap.sv
// kerbin_axi_id_remap: AXI4 ID-width reducer in front of the MIG DDR3 port.
// Wide crossbar IDs are mapped onto a small set of output IDs through one
// remap table per direction (AR/R and AW/B); R and B beats get their
// original ID back. Transactions that share an input ID share an output ID,
// so AXI same-ID ordering survives the compression.
//   clk_i  : single clock
//   rst_ni : asynchronous active-low reset, clears both tables
//   slv    : AXI_BUS.Slave,  wide IDs, from the crossbar master port
//   mst    : AXI_BUS.Master, narrow IDs, to the DDR3 controller

// One remap table. Entry index == output ID.
//   req_* : lookup/allocation for an incoming address request
//   rsp_* : response lookup and retirement
module kerbin_axi_id_remap_table #(
   parameter int unsigned ID_IN    = 10,
   parameter int unsigned ID_OUT   = 4,
   parameter int unsigned MAX_TXNS = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [ID_IN-1:0]  req_id,
   input  logic              req_hs,
   output logic              req_avail,
   output logic [ID_OUT-1:0] req_idx,
   input  logic [ID_OUT-1:0] rsp_idx,
   input  logic              rsp_hs,
   input  logic              rsp_last,
   output logic [ID_IN-1:0]  rsp_orig,
   output logic              rsp_err
);
   localparam int unsigned NENT = 2**ID_OUT;
   localparam int unsigned CW   = $clog2(MAX_TXNS+1);

   logic [NENT-1:0]            vld;
   logic [NENT-1:0][ID_IN-1:0] orig;
   logic [NENT-1:0][CW-1:0]    cnt;
   logic                       hit, free;
   logic [ID_OUT-1:0]          hit_idx, free_idx;
   logic [NENT-1:0]            inc_sel, dec_sel;

   // Descending scan so the lowest-index free entry wins. Valid entries never
   // share an orig_id, so at most one can hit.
   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      free     = 1'b0;
      free_idx = '0;
      for (int i = NENT-1; i >= 0; i--) begin
         if (vld[i] && orig[i] == req_id) begin
            hit     = 1'b1;
            hit_idx = ID_OUT'(i);
         end
         if (!vld[i]) begin
            free     = 1'b1;
            free_idx = ID_OUT'(i);
         end
      end
   end

   assign req_idx   = hit ? hit_idx : free_idx;
   assign req_avail = hit ? (cnt[hit_idx] < CW'(MAX_TXNS)) : free;

   assign rsp_orig = orig[rsp_idx];
   assign rsp_err  = rsp_hs && !vld[rsp_idx];

   // A response on an invalid entry is dropped here so cnt cannot underflow.
   assign inc_sel = req_hs ? (NENT'(1) << req_idx) : '0;
   assign dec_sel = (rsp_hs && rsp_last && vld[rsp_idx]) ? (NENT'(1) << rsp_idx) : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld  <= '0;
         orig <= '0;
         cnt  <= '0;
      end else begin
         for (int i = 0; i < NENT; i++) begin
            if (inc_sel[i] && !vld[i]) begin
               vld[i]  <= 1'b1;
               orig[i] <= req_id;
               cnt[i]  <= CW'(1);
            end else if (inc_sel[i] && !dec_sel[i]) begin
               cnt[i] <= cnt[i] + 1'b1;
            end else if (dec_sel[i] && !inc_sel[i]) begin
               cnt[i] <= cnt[i] - 1'b1;
               if (cnt[i] == CW'(1)) vld[i] <= 1'b0;
            end
         end
      end
   end
endmodule

module kerbin_axi_id_remap #(
   parameter int unsigned AXI_ADDR_WIDTH   = 64,
   parameter int unsigned AXI_DATA_WIDTH   = 64,
   parameter int unsigned AXI_USER_WIDTH   = 1,
   parameter int unsigned AXI_ID_WIDTH_IN  = 10,
   parameter int unsigned AXI_ID_WIDTH_OUT = 4,
   parameter int unsigned MAX_TXNS_PER_ID  = 4
) (
   input logic    clk_i,
   input logic    rst_ni,
   AXI_BUS.Slave  slv,
   AXI_BUS.Master mst
);
   logic                        rd_avail, wr_avail, rd_err, wr_err;
   logic                        ar_hs, aw_hs, r_hs, b_hs;
   logic [AXI_ID_WIDTH_OUT-1:0] rd_idx, wr_idx;

   assign ar_hs = slv.ar_valid && mst.ar_ready && rd_avail;
   assign aw_hs = slv.aw_valid && mst.aw_ready && wr_avail;
   assign r_hs  = mst.r_valid && slv.r_ready;
   assign b_hs  = mst.b_valid && slv.b_ready;

   kerbin_axi_id_remap_table #(
      .ID_IN(AXI_ID_WIDTH_IN), .ID_OUT(AXI_ID_WIDTH_OUT), .MAX_TXNS(MAX_TXNS_PER_ID)
   ) u_rd_tbl (
      .clk_i, .rst_ni,
      .req_id(slv.ar_id), .req_hs(ar_hs), .req_avail(rd_avail), .req_idx(rd_idx),
      .rsp_idx(mst.r_id), .rsp_hs(r_hs), .rsp_last(mst.r_last),
      .rsp_orig(slv.r_id), .rsp_err(rd_err)
   );

   // Every B beat closes exactly one write.
   kerbin_axi_id_remap_table #(
      .ID_IN(AXI_ID_WIDTH_IN), .ID_OUT(AXI_ID_WIDTH_OUT), .MAX_TXNS(MAX_TXNS_PER_ID)
   ) u_wr_tbl (
      .clk_i, .rst_ni,
      .req_id(slv.aw_id), .req_hs(aw_hs), .req_avail(wr_avail), .req_idx(wr_idx),
      .rsp_idx(mst.b_id), .rsp_hs(b_hs), .rsp_last(1'b1),
      .rsp_orig(slv.b_id), .rsp_err(wr_err)
   );

   // AW: gated by table availability, ID replaced.
   assign mst.aw_valid  = slv.aw_valid && wr_avail;
   assign slv.aw_ready  = mst.aw_ready && wr_avail;
   assign mst.aw_id     = wr_idx;
   assign mst.aw_addr   = slv.aw_addr;
   assign mst.aw_len    = slv.aw_len;
   assign mst.aw_size   = slv.aw_size;
   assign mst.aw_burst  = slv.aw_burst;
   assign mst.aw_lock   = slv.aw_lock;
   assign mst.aw_cache  = slv.aw_cache;
   assign mst.aw_prot   = slv.aw_prot;
   assign mst.aw_qos    = slv.aw_qos;
   assign mst.aw_region = slv.aw_region;
   assign mst.aw_user   = slv.aw_user;

   // W follows AW acceptance order, so it needs no ID handling.
   assign mst.w_data  = slv.w_data;
   assign mst.w_strb  = slv.w_strb;
   assign mst.w_last  = slv.w_last;
   assign mst.w_user  = slv.w_user;
   assign mst.w_valid = slv.w_valid;
   assign slv.w_ready = mst.w_ready;

   assign slv.b_resp  = mst.b_resp;
   assign slv.b_user  = mst.b_user;
   assign slv.b_valid = mst.b_valid;
   assign mst.b_ready = slv.b_ready;

   // AR: gated by table availability, ID replaced.
   assign mst.ar_valid  = slv.ar_valid && rd_avail;
   assign slv.ar_ready  = mst.ar_ready && rd_avail;
   assign mst.ar_id     = rd_idx;
   assign mst.ar_addr   = slv.ar_addr;
   assign mst.ar_len    = slv.ar_len;
   assign mst.ar_size   = slv.ar_size;
   assign mst.ar_burst  = slv.ar_burst;
   assign mst.ar_lock   = slv.ar_lock;
   assign mst.ar_cache  = slv.ar_cache;
   assign mst.ar_prot   = slv.ar_prot;
   assign mst.ar_qos    = slv.ar_qos;
   assign mst.ar_region = slv.ar_region;
   assign mst.ar_user   = slv.ar_user;

   assign slv.r_data  = mst.r_data;
   assign slv.r_resp  = mst.r_resp;
   assign slv.r_last  = mst.r_last;
   assign slv.r_user  = mst.r_user;
   assign slv.r_valid = mst.r_valid;
   assign mst.r_ready = slv.r_ready;

   // Bus instances must match the widths this block was built for.
   assert property (@(posedge clk_i)
      $bits(slv.ar_addr) == AXI_ADDR_WIDTH && $bits(mst.w_data) == AXI_DATA_WIDTH &&
      $bits(slv.ar_user) == AXI_USER_WIDTH && $bits(slv.ar_id) == AXI_ID_WIDTH_IN &&
      $bits(mst.ar_id) == AXI_ID_WIDTH_OUT);

   // Responses must refer to an outstanding transaction.
   assert property (@(posedge clk_i) disable iff (!rst_ni) !rd_err);
   assert property (@(posedge clk_i) disable iff (!rst_ni) !wr_err);
endmodule

// File: tb/tb_kerbin_axi_id_remap.sv
module tb_kerbin_axi_id_remap;
   localparam int AW = 64, DW = 64, UW = 1, IDI = 10, IDO = 4, MAXT = 4, NENT = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   AXI_BUS #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IDI), .AXI_USER_WIDTH(UW)) slv_bus ();
   AXI_BUS #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IDO), .AXI_USER_WIDTH(UW)) mst_bus ();

   kerbin_axi_id_remap #(
      .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_USER_WIDTH(UW),
      .AXI_ID_WIDTH_IN(IDI), .AXI_ID_WIDTH_OUT(IDO), .MAX_TXNS_PER_ID(MAXT)
   ) dut (.clk_i(clk), .rst_ni(rst_n), .slv(slv_bus), .mst(mst_bus));

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model: list of outstanding transactions -------
   // d=0 read, d=1 write. Output IDs in use are those of outstanding txns.
   typedef struct { int d; int orig; int oid; } txn_t;
   txn_t outst[$];

   function automatic int n_out(input int d, input int oid);
      int n = 0;
      foreach (outst[k]) if (outst[k].d == d && outst[k].oid == oid) n++;
      return n;
   endfunction

   function automatic void lookup(input int d, input int id, output bit av, output int idx);
      idx = -1;
      av  = 1'b0;
      foreach (outst[k]) if (outst[k].d == d && outst[k].orig == id) idx = outst[k].oid;
      if (idx >= 0) av = (n_out(d, idx) < MAXT);
      else
         for (int o = NENT-1; o >= 0; o--)
            if (n_out(d, o) == 0) begin av = 1'b1; idx = o; end
   endfunction

   function automatic int orig_of(input int d, input int oid);
      foreach (outst[k]) if (outst[k].d == d && outst[k].oid == oid) return outst[k].orig;
      return -1;
   endfunction

   function automatic void retire(input int d, input int oid);
      for (int k = 0; k < outst.size(); k++)
         if (outst[k].d == d && outst[k].oid == oid) begin outst.delete(k); return; end
   endfunction

   function automatic int pick(input int d);
      int ks[$];
      foreach (outst[k]) if (outst[k].d == d) ks.push_back(outst[k].oid);
      if (ks.size() == 0) return -1;
      return ks[$urandom_range(0, ks.size()-1)];
   endfunction

   // ---------------- drive helpers -------------------------------------------
   task automatic idle();
      slv_bus.aw_id = '0; slv_bus.aw_addr = '0; slv_bus.aw_len = '0; slv_bus.aw_size = 3'd3;
      slv_bus.aw_burst = 2'b01; slv_bus.aw_lock = 1'b0; slv_bus.aw_cache = '0; slv_bus.aw_prot = '0;
      slv_bus.aw_qos = '0; slv_bus.aw_region = '0; slv_bus.aw_user = '0; slv_bus.aw_valid = 1'b0;
      slv_bus.w_data = '0; slv_bus.w_strb = '1; slv_bus.w_last = 1'b1; slv_bus.w_user = '0;
      slv_bus.w_valid = 1'b0; slv_bus.b_ready = 1'b0;
      slv_bus.ar_id = '0; slv_bus.ar_addr = '0; slv_bus.ar_len = '0; slv_bus.ar_size = 3'd3;
      slv_bus.ar_burst = 2'b01; slv_bus.ar_lock = 1'b0; slv_bus.ar_cache = '0; slv_bus.ar_prot = '0;
      slv_bus.ar_qos = '0; slv_bus.ar_region = '0; slv_bus.ar_user = '0; slv_bus.ar_valid = 1'b0;
      slv_bus.r_ready = 1'b0;
      mst_bus.aw_ready = 1'b0; mst_bus.w_ready = 1'b0; mst_bus.ar_ready = 1'b0;
      mst_bus.b_id = '0; mst_bus.b_resp = '0; mst_bus.b_user = '0; mst_bus.b_valid = 1'b0;
      mst_bus.r_id = '0; mst_bus.r_data = '0; mst_bus.r_resp = '0; mst_bus.r_last = 1'b0;
      mst_bus.r_user = '0; mst_bus.r_valid = 1'b0;
   endtask

   // Inputs change right after the falling edge; outputs are sampled 2 units later.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      idle();
      outst.delete();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic ar_go(input int id, input int exp_idx, input string nm);
      slv_bus.ar_valid = 1'b1; slv_bus.ar_id = IDI'(id); mst_bus.ar_ready = 1'b1;
      #2;
      chk({nm, " ar_id"}, 64'(mst_bus.ar_id), 64'(exp_idx));
      chk({nm, " ar_ready"}, 64'(slv_bus.ar_ready), 64'd1);
      tick();
      slv_bus.ar_valid = 1'b0; mst_bus.ar_ready = 1'b0;
   endtask

   task automatic aw_go(input int id, input int exp_idx, input string nm);
      slv_bus.aw_valid = 1'b1; slv_bus.aw_id = IDI'(id); mst_bus.aw_ready = 1'b1;
      #2;
      chk({nm, " aw_id"}, 64'(mst_bus.aw_id), 64'(exp_idx));
      chk({nm, " aw_ready"}, 64'(slv_bus.aw_ready), 64'd1);
      tick();
      slv_bus.aw_valid = 1'b0; mst_bus.aw_ready = 1'b0;
   endtask

   task automatic r_beat(input int idx, input bit last, input int exp_orig, input string nm);
      mst_bus.r_valid = 1'b1; mst_bus.r_id = IDO'(idx); mst_bus.r_last = last; slv_bus.r_ready = 1'b1;
      #2;
      chk({nm, " r_id"}, 64'(slv_bus.r_id), 64'(exp_orig));
      tick();
      mst_bus.r_valid = 1'b0; mst_bus.r_last = 1'b0; slv_bus.r_ready = 1'b0;
   endtask

   task automatic b_beat(input int idx, input int exp_orig, input string nm);
      mst_bus.b_valid = 1'b1; mst_bus.b_id = IDO'(idx); slv_bus.b_ready = 1'b1;
      #2;
      chk({nm, " b_id"}, 64'(slv_bus.b_id), 64'(exp_orig));
      tick();
      mst_bus.b_valid = 1'b0; slv_bus.b_ready = 1'b0;
   endtask

   // Probe which output ID a new request would get, without handshaking.
   task automatic ar_probe(input int id, input int exp_idx, input string nm);
      slv_bus.ar_valid = 1'b1; slv_bus.ar_id = IDI'(id); mst_bus.ar_ready = 1'b0;
      #2;
      chk(nm, 64'(mst_bus.ar_id), 64'(exp_idx));
      tick();
      slv_bus.ar_valid = 1'b0;
   endtask

   // ---------------- reset-state vector table --------------------------------
   // ctl = {ar_valid, mst ar_ready, aw_valid, mst aw_ready, w_valid, mst w_ready}
   // exp = {mst ar_valid, slv ar_ready, mst aw_valid, slv aw_ready, mst w_valid, slv w_ready}
   typedef struct {
      logic [5:0]  ctl;
      logic [9:0]  id;
      logic [63:0] addr;
      logic [63:0] data;
      logic [5:0]  exp;
   } vec_t;
   vec_t vt[6];

   bit arv, arr, rv, rr, rl, awv, awr, bv, br, av_r, av_w;
   int arid, awid, rid, bid, idx_r, idx_w;
   logic [63:0] wd;

   initial begin
      vt[0] = '{6'b110010, 10'h155, 64'h1000,                64'hDEAD_BEEF,           6'b110010};
      vt[1] = '{6'b101101, 10'h3FF, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0123_4567_89AB_CDEF, 6'b101101};
      vt[2] = '{6'b011011, 10'h000, 64'h0,                   64'hFFFF_FFFF_FFFF_FFFF, 6'b011011};
      vt[3] = '{6'b000000, 10'h2AA, 64'h8000_0000_0000_0000, 64'h5555,                6'b000000};
      vt[4] = '{6'b111111, 10'h001, 64'h42,                  64'hA5A5,                6'b111111};
      vt[5] = '{6'b001001, 10'h1F0, 64'h7,                   64'h1,                   6'b001001};

      idle();
      rst_n = 1'b0;
      @(negedge clk);
      // Held in reset: empty tables, so every request is available and maps to ID 0.
      for (int i = 0; i < 6; i++) begin
         slv_bus.ar_valid = vt[i].ctl[5]; mst_bus.ar_ready = vt[i].ctl[4];
         slv_bus.aw_valid = vt[i].ctl[3]; mst_bus.aw_ready = vt[i].ctl[2];
         slv_bus.w_valid  = vt[i].ctl[1]; mst_bus.w_ready  = vt[i].ctl[0];
         slv_bus.ar_id = vt[i].id; slv_bus.aw_id = vt[i].id ^ 10'h3FF;
         slv_bus.ar_addr = vt[i].addr; slv_bus.aw_addr = ~vt[i].addr;
         slv_bus.w_data = vt[i].data;
         #1;
         chk($sformatf("vec%0d ctl", i), 64'({mst_bus.ar_valid, slv_bus.ar_ready, mst_bus.aw_valid,
                                              slv_bus.aw_ready, mst_bus.w_valid, slv_bus.w_ready}),
             64'(vt[i].exp));
         chk($sformatf("vec%0d ar_id", i), 64'(mst_bus.ar_id), 64'd0);
         chk($sformatf("vec%0d aw_id", i), 64'(mst_bus.aw_id), 64'd0);
         chk($sformatf("vec%0d ar_addr", i), mst_bus.ar_addr, vt[i].addr);
         chk($sformatf("vec%0d aw_addr", i), mst_bus.aw_addr, ~vt[i].addr);
         chk($sformatf("vec%0d w_data", i), mst_bus.w_data, vt[i].data);
      end

      // Single read burst.
      do_reset();
      slv_bus.ar_len = 8'd3;
      ar_go('h155, 0, "single");
      for (int b = 0; b < 4; b++) r_beat(0, b == 3, 'h155, $sformatf("single beat%0d", b));
      ar_probe('h0AA, 0, "single freed");

      // Same-ID write sharing.
      do_reset();
      for (int k = 0; k < 3; k++) aw_go('h021, 0, $sformatf("share aw%0d", k));
      for (int k = 0; k < 3; k++) b_beat(0, 'h021, $sformatf("share b%0d", k));
      slv_bus.aw_valid = 1'b1; slv_bus.aw_id = IDI'('h099); mst_bus.aw_ready = 1'b0;
      #2;
      chk("share freed aw_id", 64'(mst_bus.aw_id), 64'd0);
      tick();
      slv_bus.aw_valid = 1'b0;

      // Full table: 17th distinct ID waits for a free entry.
      do_reset();
      for (int k = 0; k < NENT; k++) ar_go('h100 + k, k, $sformatf("full ar%0d", k));
      slv_bus.ar_valid = 1'b1; slv_bus.ar_id = IDI'('h200); mst_bus.ar_ready = 1'b1;
      mst_bus.r_valid = 1'b1; mst_bus.r_id = IDO'(5); mst_bus.r_last = 1'b1; slv_bus.r_ready = 1'b1;
      #2;
      chk("full stall ar_ready", 64'(slv_bus.ar_ready), 64'd0);
      chk("full stall mst ar_valid", 64'(mst_bus.ar_valid), 64'd0);
      chk("full r_id", 64'(slv_bus.r_id), 64'h105);
      tick();
      mst_bus.r_valid = 1'b0; mst_bus.r_last = 1'b0; slv_bus.r_ready = 1'b0;
      #2;
      chk("full resume mst ar_valid", 64'(mst_bus.ar_valid), 64'd1);
      chk("full resume ar_id", 64'(mst_bus.ar_id), 64'd5);
      chk("full resume ar_ready", 64'(slv_bus.ar_ready), 64'd1);
      tick();
      slv_bus.ar_valid = 1'b0; mst_bus.ar_ready = 1'b0;

      // Saturation at MAX_TXNS_PER_ID on one entry.
      do_reset();
      for (int k = 0; k < MAXT; k++) ar_go('h033, 0, $sformatf("sat ar%0d", k));
      slv_bus.ar_valid = 1'b1; slv_bus.ar_id = IDI'('h033); mst_bus.ar_ready = 1'b1;
      #2;
      chk("sat stall ar_ready", 64'(slv_bus.ar_ready), 64'd0);
      chk("sat stall mst ar_valid", 64'(mst_bus.ar_valid), 64'd0);
      tick();
      mst_bus.r_valid = 1'b1; mst_bus.r_id = '0; mst_bus.r_last = 1'b1; slv_bus.r_ready = 1'b1;
      #2;
      chk("sat stall at r_last", 64'(slv_bus.ar_ready), 64'd0);
      chk("sat r_id", 64'(slv_bus.r_id), 64'h033);
      tick();
      mst_bus.r_valid = 1'b0; mst_bus.r_last = 1'b0; slv_bus.r_ready = 1'b0;
      #2;
      chk("sat resume ar_ready", 64'(slv_bus.ar_ready), 64'd1);
      chk("sat resume ar_id", 64'(mst_bus.ar_id), 64'd0);
      tick();
      slv_bus.ar_valid = 1'b0; mst_bus.ar_ready = 1'b0;

      // Same-cycle hit and last beat on entry 2 (cnt=1).
      do_reset();
      for (int k = 0; k < 3; k++) ar_go('h300 + k, k, $sformatf("simul ar%0d", k));
      slv_bus.ar_valid = 1'b1; slv_bus.ar_id = IDI'('h302); mst_bus.ar_ready = 1'b1;
      mst_bus.r_valid = 1'b1; mst_bus.r_id = IDO'(2); mst_bus.r_last = 1'b1; slv_bus.r_ready = 1'b1;
      #2;
      chk("simul ar_id", 64'(mst_bus.ar_id), 64'd2);
      chk("simul ar_ready", 64'(slv_bus.ar_ready), 64'd1);
      chk("simul r_id", 64'(slv_bus.r_id), 64'h302);
      tick();
      idle();
      ar_probe('h3AB, 3, "simul entry2 kept");
      r_beat(2, 1'b1, 'h302, "simul late");
      ar_probe('h3AB, 2, "simul entry2 freed");

      // Reset with writes outstanding.
      do_reset();
      for (int k = 0; k < 3; k++) aw_go('h010 + k, k, $sformatf("rst aw%0d", k));
      do_reset();
      aw_go('h3FF, 0, "rst fresh");

      // Randomized traffic against the transaction-list model.
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         arv = ($urandom_range(0, 3) != 0); arr = ($urandom_range(0, 3) != 0);
         awv = ($urandom_range(0, 3) != 0); awr = ($urandom_range(0, 3) != 0);
         arid = 'h40 + $urandom_range(0, 19);
         awid = 'h40 + $urandom_range(0, 19);
         rid = pick(0); bid = pick(1);
         rv = (rid >= 0) && ($urandom_range(0, 1) == 1);
         bv = (bid >= 0) && ($urandom_range(0, 2) == 0);
         rl = ($urandom_range(0, 1) == 1);
         rr = ($urandom_range(0, 3) != 0); br = ($urandom_range(0, 3) != 0);
         wd = {$urandom, $urandom};
         slv_bus.ar_valid = arv; slv_bus.ar_id = IDI'(arid); mst_bus.ar_ready = arr;
         slv_bus.aw_valid = awv; slv_bus.aw_id = IDI'(awid); mst_bus.aw_ready = awr;
         slv_bus.w_valid = 1'b1; slv_bus.w_data = wd; mst_bus.w_ready = 1'b1;
         mst_bus.r_valid = rv; mst_bus.r_id = IDO'(rv ? rid : 0); mst_bus.r_last = rl; slv_bus.r_ready = rr;
         mst_bus.b_valid = bv; mst_bus.b_id = IDO'(bv ? bid : 0); slv_bus.b_ready = br;
         #2;
         lookup(0, arid, av_r, idx_r);
         lookup(1, awid, av_w, idx_w);
         chk("rnd mst ar_valid", 64'(mst_bus.ar_valid), 64'(arv && av_r));
         chk("rnd slv ar_ready", 64'(slv_bus.ar_ready), 64'(arr && av_r));
         if (arv && av_r) chk("rnd ar_id", 64'(mst_bus.ar_id), 64'(idx_r));
         chk("rnd mst aw_valid", 64'(mst_bus.aw_valid), 64'(awv && av_w));
         chk("rnd slv aw_ready", 64'(slv_bus.aw_ready), 64'(awr && av_w));
         if (awv && av_w) chk("rnd aw_id", 64'(mst_bus.aw_id), 64'(idx_w));
         if (rv) chk("rnd r_id", 64'(slv_bus.r_id), 64'(orig_of(0, rid)));
         if (bv) chk("rnd b_id", 64'(slv_bus.b_id), 64'(orig_of(1, bid)));
         chk("rnd w_data", mst_bus.w_data, wd);
         if (arv && arr && av_r) outst.push_back('{0, arid, idx_r});
         if (awv && awr && av_w) outst.push_back('{1, awid, idx_w});
         if (rv && rr && rl) retire(0, rid);
         if (bv && br) retire(1, bid);
         tick();
      end
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/kerbin_axi_id_remap.md
# kerbin_axi_id_remap

AXI4 ID-width reducer between the SoC crossbar's DDR3 master port and the MIG DDR3 controller's AXI slave port. It compresses the crossbar's wide, origin-tagged transaction IDs into the controller's narrow ID space. It tracks outstanding reads and writes in per-direction remap tables and restores the original ID on every R and B beat. Ordering is preserved: transactions sharing an input ID always share an output ID.

## Interface
Parameters:
- AXI_ADDR_WIDTH, 64, address width (pass-through)
- AXI_DATA_WIDTH, 64, data width (pass-through)
- AXI_USER_WIDTH, 1, user width (pass-through)
- AXI_ID_WIDTH_IN, 10, ID width on the crossbar side
- AXI_ID_WIDTH_OUT, 4, ID width on the controller side; each table has 2**AXI_ID_WIDTH_OUT entries
- MAX_TXNS_PER_ID, 4, maximum outstanding transactions per table entry (≥1)

Ports:
- clk_i  in  1  single clock domain for the whole block
- rst_ni  in  1  asynchronous active-low reset
- slv  AXI_BUS.Slave  ID=AXI_ID_WIDTH_IN  from the crossbar master port
- mst  AXI_BUS.Master  ID=AXI_ID_WIDTH_OUT  to the DDR3 controller

## Operation
- There are two independent tables, RD (AR/R) and WR (AW/B). Each entry holds a valid bit, orig_id[AXI_ID_WIDTH_IN], and cnt[$clog2(MAX_TXNS_PER_ID+1)].
- The entry index is the output ID.
- Lookup (AR, likewise AW) is combinational on the registered table:
  - hit: a valid entry with orig_id == slv.ar_id exists. Use that index. Accept only if cnt < MAX_TXNS_PER_ID.
  - miss: allocate the lowest-index invalid entry. Accept only if such an entry exists.
  - avail = (hit && cnt<MAX) || (!hit && free_exists).
- Address channel gating:
  - mst.ar_valid = slv.ar_valid && avail
  - slv.ar_ready = mst.ar_ready && avail
  - mst.ar_id = chosen index. All other AR fields pass through unchanged.
- On an AR handshake:
  - hit: cnt++.
  - miss: valid<=1, orig_id<=slv.ar_id, cnt<=1.
- R channel: slv.r_id = RD[mst.r_id].orig_id, and all other fields pass through combinationally. On a handshake with r_last=1, cnt--. When cnt reaches 0, valid<=0.
- B channel: slv.b_id = WR[mst.b_id].orig_id. Every B handshake decrements cnt; at 0, valid<=0.
- W channel is a full combinational pass-through. AW acceptance order equals W order, so no tracking is needed.
- AXI stability: avail for a pending request can only change via this channel's own handshake or a free. A free only increases availability, so a raised mst.ar_valid/aw_valid stays high until handshake. valid never depends on ready.
- A response carrying an ID whose entry is invalid is a protocol error. An assertion fires; the table is unchanged (cnt does not underflow).

## Timing
- Zero-cycle latency on all five channels. Table state updates on the clk_i edge following a handshake.
- Reset: all entries valid=0, cnt=0.
  - Outputs are combinational: mst.ar_valid/aw_valid follow slv valids (avail=1 when empty); slv.ar_ready/aw_ready follow mst readys.
  - All other outputs follow their inputs.
- Same-cycle alloc and free on one table:
  - Same entry (hit with cnt++ and r_last/B cnt--): net cnt unchanged, entry stays valid.
  - An entry freed this cycle is not allocatable until the next cycle, because allocation uses registered state.
- Saturation: a hit at cnt==MAX_TXNS_PER_ID stalls the request. Accept resumes in the cycle after the first decrement.
- Full table: a miss stalls until any entry frees. Hits on existing entries proceed.
- Reset mid-burst clears all tables. Later responses for pre-reset transactions are errors; the system resets the controller together with this block.

## Test plan
- Single read: AR id=0x155, len=3 → mst.ar_id=0. Four R beats return with slv.r_id=0x155. After r_last, entry 0 is invalid.
- Same-ID sharing: three AWs with id=0x021 → all use mst.aw_id=0, cnt=3. After three B beats with b_id=0x021, entry 0 is freed.
- Table full: 16 ARs with distinct IDs 0x100..0x10F → output IDs 0..15. A 17th AR with id=0x200 stalls (slv.ar_ready=0, mst.ar_valid=0). An r_last on ID 5 frees entry 5, and next cycle the stalled AR issues as mst.ar_id=5.
- Saturation: five ARs with id=0x033 and MAX_TXNS_PER_ID=4 → the fifth stalls. It is accepted the cycle after the first r_last on that entry.
- Simultaneous: an AR hit on entry 2 in the same cycle as r_last for entry 2 with cnt=1 → cnt stays 1, entry stays valid, and the later r_last returns the original ID.
- Reset mid-operation: deassert rst_ni with 3 outstanding writes → all entries are invalid, and a fresh AW id=0x3FF maps to mst.aw_id=0.
